// File: rtl/lin_interp.sv
// Purpose : linear interpolator, emits N = 1<<SHIFT evenly spaced samples between consecutive inputs.
// Latency : first beat of a burst is valid the cycle after the sample that completes the pair is accepted.
// Backpr. : iready drops for the whole burst; odata and the beat counter hold while oready is low.
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous, active-high reset
//   idata/ivalid     input sample and its valid
//   iready           high when a sample can be accepted (EMPTY or WAIT)
//   odata/ovalid     interpolated sample and its valid (EMIT only)
//   oready           downstream accepts odata
module lin_interp #(
    parameter int WIDTH  = 32,
    parameter int SHIFT  = 2,
    parameter int SIGNED = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] idata,
    input  logic             ivalid,
    output logic             iready,
    output logic [WIDTH-1:0] odata,
    output logic             ovalid,
    input  logic             oready
);

    localparam int AW = WIDTH + SHIFT + 1;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_EMIT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH:0]   delta_q, delta_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [SHIFT-1:0] k_q, k_d;

    logic             in_fire;
    logic             out_fire;
    logic [WIDTH:0]   p_ext;
    logic [WIDTH:0]   c_ext;
    logic [AW-1:0]    p_acc;
    logic [AW-1:0]    delta_acc;

    // Widen a sample by one bit so the difference of any two samples
    // is representable, honouring the sample signedness.
    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] x);
        if (SIGNED != 0) begin
            ext = {x[WIDTH-1], x};
        end else begin
            ext = {1'b0, x};
        end
    endfunction

    assign iready   = (state_q != ST_EMIT);
    assign ovalid   = (state_q == ST_EMIT);
    assign in_fire  = ivalid & iready;
    assign out_fire = ovalid & oready;

    assign p_ext = ext(p_q);
    assign c_ext = ext(idata);

    // The extended values are already sign-correct at WIDTH+1 bits, so
    // growing them to accumulator width is always a sign extension.
    // P<<SHIFT still fits: a (WIDTH+1)-bit signed value times N needs
    // exactly WIDTH+SHIFT+1 signed bits.
    assign p_acc     = {{SHIFT{p_ext[WIDTH]}}, p_ext} << SHIFT;
    assign delta_acc = {{SHIFT{delta_q[WIDTH]}}, delta_q};

    // The accumulator holds P*N + k*(C-P); an arithmetic shift right by
    // SHIFT is the floor division, and every result lies between P and
    // C so the low WIDTH bits of the quotient are the exact sample.
    assign odata = acc_q[SHIFT +: WIDTH];

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        delta_d = delta_q;
        acc_d   = acc_q;
        k_d     = k_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    p_d     = idata;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (in_fire) begin
                    // The burst runs entirely from acc/delta, so the new
                    // sample can become the next P right away; this is
                    // indistinguishable from updating P on the last beat.
                    p_d     = idata;
                    delta_d = c_ext - p_ext;
                    acc_d   = p_acc;
                    k_d     = '0;
                    state_d = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (out_fire) begin
                    acc_d = acc_q + delta_acc;
                    k_d   = k_q + SHIFT'(1);
                    if (k_q == '1) begin
                        state_d = ST_WAIT;
                    end
                end
            end

            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            p_q     <= '0;
            delta_q <= '0;
            acc_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            delta_q <= delta_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
        end
    end

    // Guard bit and fraction bits of the accumulator never reach odata.
    logic unused_acc_bits;
    assign unused_acc_bits = ^{acc_q[AW-1], acc_q[SHIFT-1:0]};

endmodule

// File: tb/tb_lin_interp.sv
module tb_lin_interp;

    localparam int SH = 2;
    localparam int N  = 1 << SH;

    logic        clock;
    logic        u_reset, s_reset;
    logic [31:0] u_idata, s_idata;
    logic        u_ivalid, s_ivalid;
    logic        u_iready, s_iready;
    logic [31:0] u_odata, s_odata;
    logic        u_ovalid, s_ovalid;
    logic        u_oready, s_oready;

    int errors = 0;
    int checks = 0;
    bit rnd    = 0;

    lin_interp #(.WIDTH(32), .SHIFT(SH), .SIGNED(0)) u_dut (
        .clock (clock),
        .reset (u_reset),
        .idata (u_idata),
        .ivalid(u_ivalid),
        .iready(u_iready),
        .odata (u_odata),
        .ovalid(u_ovalid),
        .oready(u_oready)
    );

    lin_interp #(.WIDTH(32), .SHIFT(SH), .SIGNED(1)) s_dut (
        .clock (clock),
        .reset (s_reset),
        .idata (s_idata),
        .ivalid(s_ivalid),
        .iready(s_iready),
        .odata (s_odata),
        .ovalid(s_ovalid),
        .oready(s_oready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: beat k between p and c is floor((p*N + k*(c-p)) / N).
    function automatic logic [31:0] model_beat(input logic [31:0] p, input logic [31:0] c,
                                               input int k, input bit sgn);
        longint pe, ce, v;
        pe = sgn ? {{32{p[31]}}, p} : {32'b0, p};
        ce = sgn ? {{32{c[31]}}, c} : {32'b0, c};
        v  = pe * N + longint'(k) * (ce - pe);
        v  = v >>> SH;
        return v[31:0];
    endfunction

    // Scoreboard state per DUT: pending expected beats, last sample, observed outputs.
    logic [31:0] uq[$], sq[$], ugot[$], sgot[$];
    logic [31:0] u_prev, s_prev;
    bit          u_have = 0, s_have = 0;

    always @(negedge clock) begin
        if (u_reset) begin
            uq.delete();
            u_have = 0;
        end else begin
            chk("u_ovalid", 32'(u_ovalid), 32'(uq.size() != 0));
            chk("u_iready", 32'(u_iready), 32'(uq.size() == 0));
            if (uq.size() != 0) begin
                chk("u_odata", u_odata, uq[0]);
                if (u_ovalid && u_oready) begin
                    ugot.push_back(u_odata);
                    void'(uq.pop_front());
                end
            end
            if (u_ivalid && u_iready) begin
                if (u_have)
                    for (int k = 0; k < N; k++) uq.push_back(model_beat(u_prev, u_idata, k, 1'b0));
                u_prev = u_idata;
                u_have = 1;
            end
        end
    end

    always @(negedge clock) begin
        if (s_reset) begin
            sq.delete();
            s_have = 0;
        end else begin
            chk("s_ovalid", 32'(s_ovalid), 32'(sq.size() != 0));
            chk("s_iready", 32'(s_iready), 32'(sq.size() == 0));
            if (sq.size() != 0) begin
                chk("s_odata", s_odata, sq[0]);
                if (s_ovalid && s_oready) begin
                    sgot.push_back(s_odata);
                    void'(sq.pop_front());
                end
            end
            if (s_ivalid && s_iready) begin
                if (s_have)
                    for (int k = 0; k < N; k++) sq.push_back(model_beat(s_prev, s_idata, k, 1'b1));
                s_prev = s_idata;
                s_have = 1;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (rnd) begin
            u_oready = ($urandom_range(0, 3) != 0);
            s_oready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input bit s, input logic [31:0] v);
        int n;
        bit ok;
        n  = 0;
        ok = 0;
        if (s) begin s_idata = v; s_ivalid = 1; end
        else   begin u_idata = v; u_ivalid = 1; end
        while (!ok && n < 200) begin
            @(negedge clock);
            ok = s ? s_iready : u_iready;
            tick();
            n++;
        end
        if (s) s_ivalid = 0; else u_ivalid = 0;
        if (!ok) chk(s ? "s_send_accept" : "u_send_accept", 32'(ok), 32'(1));
    endtask

    task automatic drain(input bit s);
        int n;
        bit done;
        n    = 0;
        done = 0;
        while (!done && n < 400) begin
            @(negedge clock);
            if (s) done = !s_ovalid && (sq.size() == 0);
            else   done = !u_ovalid && (uq.size() == 0);
            n++;
        end
        tick();
        if (!done) chk(s ? "s_drain" : "u_drain", 32'(done), 32'(1));
    endtask

    task automatic rst_dut(input bit s);
        if (s) begin
            s_reset = 1; s_ivalid = 0; s_oready = 1;
            #1;
            chk("s_rst_ovalid", 32'(s_ovalid), 32'(0));
            chk("s_rst_iready", 32'(s_iready), 32'(1));
            chk("s_rst_odata", s_odata, 32'(0));
            tick(); tick();
            s_reset = 0;
            sgot.delete();
        end else begin
            u_reset = 1; u_ivalid = 0; u_oready = 1;
            #1;
            chk("u_rst_ovalid", 32'(u_ovalid), 32'(0));
            chk("u_rst_iready", 32'(u_iready), 32'(1));
            chk("u_rst_odata", u_odata, 32'(0));
            tick(); tick();
            u_reset = 0;
            ugot.delete();
        end
    endtask

    task automatic check_seq(input string name, input bit s, input logic [31:0] e[$]);
        logic [31:0] g[$];
        if (s) g = sgot; else g = ugot;
        chk({name, "_len"}, 32'(g.size()), 32'(e.size()));
        foreach (e[i]) begin
            if (i < g.size()) chk(name, g[i], e[i]);
        end
    endtask

    task automatic rand_run(input bit s, input int count);
        logic [31:0] v, last;
        last = 0;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = 32'($urandom_range(0, 40)) - (s ? 32'd20 : 32'd0);
                2:       v = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: v = last;
            endcase
            send(s, v);
            last = v;
        end
        drain(s);
    endtask

    initial begin
        logic [31:0] e[$];
        u_reset = 1; s_reset = 1;
        u_idata = 0; s_idata = 0;
        u_ivalid = 0; s_ivalid = 0;
        u_oready = 1; s_oready = 1;
        tick(); tick();
        rst_dut(1'b0);
        rst_dut(1'b1);

        // Basic bursts, one idle cycle between them.
        send(1'b0, 32'd1); send(1'b0, 32'd5); send(1'b0, 32'd9);
        drain(1'b0);
        e = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        check_seq("basic", 1'b0, e);

        // Floor rounding.
        rst_dut(1'b0);
        send(1'b0, 32'd0); send(1'b0, 32'd3);
        drain(1'b0);
        e = '{32'd0, 32'd0, 32'd1, 32'd2};
        check_seq("floor", 1'b0, e);

        // Equal samples.
        rst_dut(1'b0);
        send(1'b0, 32'd7); send(1'b0, 32'd7);
        drain(1'b0);
        e = '{32'd7, 32'd7, 32'd7, 32'd7};
        check_seq("equal", 1'b0, e);

        // Unsigned large descending step.
        rst_dut(1'b0);
        send(1'b0, 32'hFFFF_FFFC); send(1'b0, 32'd0);
        drain(1'b0);
        e = '{32'hFFFF_FFFC, 32'hBFFF_FFFD, 32'h7FFF_FFFE, 32'h3FFF_FFFF};
        check_seq("ubig", 1'b0, e);

        // Backpressure with the next sample held on the input.
        rst_dut(1'b0);
        send(1'b0, 32'd1); send(1'b0, 32'd5);
        u_idata = 32'd9; u_ivalid = 1;
        tick();
        u_oready = 0;
        repeat (3) begin
            chk("bp_odata", u_odata, 32'd2);
            chk("bp_ovalid", 32'(u_ovalid), 32'(1));
            chk("bp_iready", 32'(u_iready), 32'(0));
            tick();
        end
        u_oready = 1;
        send(1'b0, 32'd9);
        drain(1'b0);
        e = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        check_seq("bp", 1'b0, e);

        // Reset in the middle of a burst.
        rst_dut(1'b0);
        send(1'b0, 32'd1); send(1'b0, 32'd5);
        tick();
        chk("mid_odata", u_odata, 32'd2);
        u_reset = 1;
        #1;
        chk("mid_rst_ovalid", 32'(u_ovalid), 32'(0));
        chk("mid_rst_iready", 32'(u_iready), 32'(1));
        tick();
        u_reset = 0;
        ugot.delete();
        send(1'b0, 32'd10); send(1'b0, 32'd14);
        drain(1'b0);
        e = '{32'd10, 32'd11, 32'd12, 32'd13};
        check_seq("mid_rst", 1'b0, e);

        // Signed, descending through zero.
        send(1'b1, 32'd4); send(1'b1, 32'd0); send(1'b1, 32'hFFFF_FFFC);
        drain(1'b1);
        e = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
        check_seq("signed", 1'b1, e);

        // Randomized traffic with random backpressure on both DUTs.
        rst_dut(1'b0);
        rst_dut(1'b1);
        rnd = 1;
        fork
            rand_run(1'b0, 150);
            rand_run(1'b1, 150);
        join
        rnd = 0;
        tick();
        u_oready = 1; s_oready = 1;
        drain(1'b0);
        drain(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
